// File: rtl/s420_cfg_loader.sv
// ============================================================================
// Module   : s420_cfg_loader
// Purpose  : Serial compare-word loader and run-length count-enable sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module s420_cfg_loader #(
  parameter int CW = 17,
  parameter int NW = 16
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          LD_REQ,
  input  logic          SI,
  input  logic          START,
  input  logic          ABORT,
  input  logic [NW-1:0] RUN_CYC,
  output logic [CW-1:0] C,
  output logic          P_0,
  output logic          LD_ACK,
  output logic          DONE,
  output logic          BUSY
);

  localparam int BW = $clog2(CW + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        r_state,   w_state_nxt;
  logic [CW-1:0] r_shadow,  w_shadow_nxt;
  logic [CW-1:0] r_c,       w_c_nxt;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [NW-1:0] r_run_cnt, w_run_cnt_nxt;
  logic          r_p0,      w_p0_nxt;
  logic          r_ack,     w_ack_nxt;
  logic          r_done,    w_done_nxt;

  // LSB-first: each new bit enters at the top, so the first bit ends at [0].
  logic [CW-1:0] w_shifted;
  logic          w_last_bit;

  assign w_shifted  = {SI, r_shadow[CW-1:1]};
  assign w_last_bit = (r_bit_cnt == BW'(CW - 1));

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_c       <= '0;
      r_bit_cnt <= '0;
      r_run_cnt <= '0;
      r_p0      <= 1'b0;
      r_ack     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_shadow_nxt;
      r_c       <= w_c_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_run_cnt <= w_run_cnt_nxt;
      r_p0      <= w_p0_nxt;
      r_ack     <= w_ack_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_c_nxt       = r_c;
    w_bit_cnt_nxt = r_bit_cnt;
    w_run_cnt_nxt = r_run_cnt;
    w_p0_nxt      = r_p0;
    w_ack_nxt     = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (LD_REQ) begin
          w_state_nxt   = ST_LOAD;
          w_bit_cnt_nxt = '0;
          w_shadow_nxt  = '0;
        end else if (START) begin
          // A zero-length run never enters RUN; it only reports completion.
          if (RUN_CYC == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_RUN;
            w_run_cnt_nxt = RUN_CYC;
            w_p0_nxt      = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (ABORT) begin
          w_state_nxt   = ST_IDLE;
          w_shadow_nxt  = '0;
          w_bit_cnt_nxt = '0;
        end else if (w_last_bit) begin
          w_c_nxt       = w_shifted;
          w_ack_nxt     = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_shadow_nxt  = '0;
          w_bit_cnt_nxt = '0;
        end else begin
          w_shadow_nxt  = w_shifted;
          w_bit_cnt_nxt = r_bit_cnt + BW'(1);
        end
      end

      ST_RUN: begin
        if (ABORT) begin
          w_state_nxt   = ST_IDLE;
          w_p0_nxt      = 1'b0;
          w_run_cnt_nxt = '0;
        end else if (r_run_cnt == NW'(1)) begin
          w_state_nxt   = ST_IDLE;
          w_p0_nxt      = 1'b0;
          w_done_nxt    = 1'b1;
          w_run_cnt_nxt = '0;
        end else begin
          w_run_cnt_nxt = r_run_cnt - NW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_p0_nxt    = 1'b0;
      end
    endcase
  end

  assign C      = r_c;
  assign P_0    = r_p0;
  assign LD_ACK = r_ack;
  assign DONE   = r_done;
  assign BUSY   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_s420_cfg_loader.sv
// ============================================================================
// Module   : tb_s420_cfg_loader
// Purpose  : Directed and random stimulus against a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_s420_cfg_loader;

  localparam int CW = 17;
  localparam int NW = 16;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          LD_REQ = 1'b0;
  logic          SI = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [NW-1:0] RUN_CYC = '0;
  logic [CW-1:0] C;
  logic          P_0, LD_ACK, DONE, BUSY;

  int total = 0;
  int bad   = 0;

  s420_cfg_loader #(.CW(CW), .NW(NW)) dut (
    .CK(CK), .RST(RST), .LD_REQ(LD_REQ), .SI(SI), .START(START),
    .ABORT(ABORT), .RUN_CYC(RUN_CYC), .C(C), .P_0(P_0),
    .LD_ACK(LD_ACK), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  // Model: a load is a queue of received bits; a run is a number of enable
  // cycles still owed. Outputs are what each transaction implies next cycle.
  typedef enum int {M_IDLE, M_LOAD, M_RUN} mode_t;
  mode_t         m_mode = M_IDLE;
  bit            m_bits[$];
  int            m_left = 0;
  logic [CW-1:0] m_c = '0;
  logic          m_p0 = 1'b0, m_ack = 1'b0, m_done = 1'b0;

  function automatic logic [CW-1:0] pack_bits();
    longint v = 0;
    for (int i = 0; i < m_bits.size(); i++) v += longint'(m_bits[i]) << i;
    return CW'(v);
  endfunction

  task automatic model_step();
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (RST) begin
      m_mode = M_IDLE; m_bits.delete(); m_left = 0; m_c = '0; m_p0 = 1'b0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (LD_REQ) begin
          m_mode = M_LOAD; m_bits.delete();
        end else if (START) begin
          m_left = int'(RUN_CYC);
          if (m_left == 0) m_done = 1'b1;
          else begin m_mode = M_RUN; m_p0 = 1'b1; end
        end
      end
      M_LOAD: begin
        if (ABORT) begin
          m_mode = M_IDLE; m_bits.delete();
        end else begin
          m_bits.push_back(SI);
          if (m_bits.size() == CW) begin
            m_c = pack_bits(); m_ack = 1'b1; m_mode = M_IDLE; m_bits.delete();
          end
        end
      end
      M_RUN: begin
        if (ABORT) begin
          m_mode = M_IDLE; m_p0 = 1'b0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_mode = M_IDLE; m_p0 = 1'b0; m_done = 1'b1; end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance DUT and model on the edge, compare 1ns later.
  task automatic cyc();
    @(posedge CK);
    model_step();
    #1;
    check("C",      32'(C),      32'(m_c));
    check("P_0",    32'(P_0),    32'(m_p0));
    check("LD_ACK", 32'(LD_ACK), 32'(m_ack));
    check("DONE",   32'(DONE),   32'(m_done));
    check("BUSY",   32'(BUSY),   32'(m_mode != M_IDLE));
    check("ACK_DONE_EXCL", 32'(LD_ACK & DONE), 32'd0);
  endtask

  logic [CW-1:0] pattern;
  int            p0_cnt, busy_cnt, ack_cnt, done_cnt;

  initial begin
    // Reset
    RST = 1'b1; cyc(); cyc();
    RST = 1'b0; cyc();

    // Load 1,0,1,1,0... -> 0x0000D
    pattern = 17'h0000D;
    busy_cnt = 0; ack_cnt = 0;
    LD_REQ = 1'b1; cyc(); LD_REQ = 1'b0;
    if (BUSY) busy_cnt++;
    for (int i = 0; i < CW; i++) begin
      SI = pattern[i]; cyc();
      if (BUSY) busy_cnt++;
      if (LD_ACK) ack_cnt++;
    end
    SI = 1'b0;
    check("load_C", 32'(C), 32'h0000D);
    check("load_ack", 32'(LD_ACK), 32'd1);
    check("load_busy_cycles", 32'(busy_cnt), 32'd17);
    cyc();
    check("load_ack_once", 32'(LD_ACK), 32'd0);

    // Run of 5
    RUN_CYC = 16'd5; START = 1'b1; cyc(); START = 1'b0;
    RUN_CYC = 16'd200;
    p0_cnt = 32'(P_0); done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (P_0) p0_cnt++;
      if (DONE) done_cnt++;
    end
    check("run5_p0", 32'(p0_cnt), 32'd5);
    check("run5_done", 32'(done_cnt), 32'd1);
    check("run5_busy", 32'(BUSY), 32'd0);

    // Zero-length run
    RUN_CYC = 16'd0; START = 1'b1; cyc(); START = 1'b0;
    check("zero_done", 32'(DONE), 32'd1);
    check("zero_p0", 32'(P_0), 32'd0);
    cyc();

    // Load aborted after 8 bits keeps C
    LD_REQ = 1'b1; cyc(); LD_REQ = 1'b0;
    for (int i = 0; i < 8; i++) begin SI = 1'b1; cyc(); end
    ABORT = 1'b1; cyc(); ABORT = 1'b0;
    check("abort_load_C", 32'(C), 32'h0000D);
    check("abort_load_ack", 32'(LD_ACK), 32'd0);
    check("abort_load_busy", 32'(BUSY), 32'd0);

    // Run of 10 aborted on its 4th enable cycle
    RUN_CYC = 16'd10; START = 1'b1; cyc(); START = 1'b0;
    cyc(); cyc(); cyc();
    check("abort_run_p0_4th", 32'(P_0), 32'd1);
    ABORT = 1'b1; cyc(); ABORT = 1'b0;
    check("abort_run_p0", 32'(P_0), 32'd0);
    check("abort_run_done", 32'(DONE), 32'd0);
    cyc(); cyc();

    // LD_REQ and START together: load wins
    RUN_CYC = 16'd3; LD_REQ = 1'b1; START = 1'b1; cyc(); LD_REQ = 1'b0; START = 1'b0;
    check("collide_busy", 32'(BUSY), 32'd1);
    check("collide_p0", 32'(P_0), 32'd0);
    cyc(); cyc();
    ABORT = 1'b1; cyc(); ABORT = 1'b0;

    // Reset in the middle of a long run
    RUN_CYC = 16'd100; START = 1'b1; cyc(); START = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    RST = 1'b1; cyc(); RST = 1'b0;
    check("rst_C", 32'(C), 32'd0);
    check("rst_outs", 32'({P_0, LD_ACK, DONE, BUSY}), 32'd0);

    // Random traffic, including RUN_CYC changing mid-run and stray ABORTs
    for (int n = 0; n < 1500; n++) begin
      RST     = ($urandom_range(0, 199) == 0);
      LD_REQ  = ($urandom_range(0, 9) == 0);
      START   = ($urandom_range(0, 6) == 0);
      ABORT   = ($urandom_range(0, 39) == 0);
      SI      = 1'($urandom);
      RUN_CYC = NW'($urandom_range(0, 12));
      cyc();
    end
    RST = 1'b0; LD_REQ = 1'b0; START = 1'b0; ABORT = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
